// File: rtl/seg_value_encoder.sv
`default_nettype none
// ============================================================================
//  Module      : seg_value_encoder
//  Description : Sequential binary-to-seven-segment front end for a two-digit
//                display. A 7-bit value is captured on Load and converted to
//                two BCD digits by a 7-step shift-add-3 engine. Both digits
//                are encoded to a..g patterns and held on the 14-bit Signal
//                bus. Values above MAX_VALUE show "--".
//                Optional build macro: LEADING_ZERO_BLANK_EN. When it is
//                defined, a zero tens digit is blanked.
//  Revision    : 1.0 - initial release
// ============================================================================
module seg_value_encoder #(
    parameter int MAX_VALUE = 99
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [6:0]  Value,
    input  logic        Load,
    output logic        Busy,
    output logic        Done,
    output logic [13:0] Signal
);

    localparam logic [1:0]  c_st_idle   = 2'd0;
    localparam logic [1:0]  c_st_shift  = 2'd1;
    localparam logic [1:0]  c_st_enc    = 2'd2;
    localparam logic [2:0]  c_last_step = 3'd6;
    localparam logic [7:0]  c_max_value = 8'(MAX_VALUE);
    localparam logic [13:0] c_ovf_pat   = 14'b0000001_0000001;

    logic [1:0]  r_state;
    logic [1:0]  w_state_nxt;
    logic [2:0]  r_step;
    logic [6:0]  r_bin;
    logic [7:0]  r_bcd;
    logic        r_ovf;
    logic        r_done;
    logic [13:0] r_signal;

    logic [7:0]  w_bcd_adj;
    logic [6:0]  w_units_seg;
    logic [6:0]  w_tens_seg;
    logic [13:0] w_signal_nxt;

    // Seven-segment pattern for one digit, MSB = segment a.
    function automatic logic [6:0] f_seg(input logic [3:0] d);
        case (d)
            4'd0:    f_seg = 7'b1111110;
            4'd1:    f_seg = 7'b0110000;
            4'd2:    f_seg = 7'b1101101;
            4'd3:    f_seg = 7'b1111001;
            4'd4:    f_seg = 7'b0110011;
            4'd5:    f_seg = 7'b1011011;
            4'd6:    f_seg = 7'b1011111;
            4'd7:    f_seg = 7'b1110000;
            4'd8:    f_seg = 7'b1111111;
            4'd9:    f_seg = 7'b1111011;
            default: f_seg = 7'b0000000;
        endcase
    endfunction

    // Control sequencing: accept in idle, seven shift steps, one encode cycle.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle:  if (Load) w_state_nxt = c_st_shift;
            c_st_shift: if (r_step == c_last_step) w_state_nxt = c_st_enc;
            c_st_enc:   w_state_nxt = c_st_idle;
            default:    w_state_nxt = c_st_idle;
        endcase
    end

    // Add-3 correction of each BCD nibble ahead of the shift.
    always_comb begin
        w_bcd_adj[3:0] = (r_bcd[3:0] >= 4'd5) ? r_bcd[3:0] + 4'd3 : r_bcd[3:0];
        w_bcd_adj[7:4] = (r_bcd[7:4] >= 4'd5) ? r_bcd[7:4] + 4'd3 : r_bcd[7:4];
    end

    // Digit encoding of the finished accumulator, with overflow override.
    always_comb begin
        w_units_seg = f_seg(r_bcd[3:0]);
`ifdef LEADING_ZERO_BLANK_EN
        w_tens_seg  = (r_bcd[7:4] == 4'd0) ? 7'b0000000 : f_seg(r_bcd[7:4]);
`else
        w_tens_seg  = f_seg(r_bcd[7:4]);
`endif
        w_signal_nxt = r_ovf ? c_ovf_pat : {w_tens_seg, w_units_seg};
    end

    // State register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Conversion datapath and output registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_step   <= 3'd0;
            r_bin    <= 7'd0;
            r_bcd    <= 8'd0;
            r_ovf    <= 1'b0;
            r_done   <= 1'b0;
            r_signal <= 14'd0;
        end else begin
            r_done <= (r_state == c_st_enc);
            case (r_state)
                c_st_idle: begin
                    if (Load) begin
                        r_bin  <= Value;
                        r_bcd  <= 8'd0;
                        r_ovf  <= ({1'b0, Value} > c_max_value);
                        r_step <= 3'd0;
                    end
                end
                c_st_shift: begin
                    r_bcd  <= {w_bcd_adj[6:0], r_bin[6]};
                    r_bin  <= {r_bin[5:0], 1'b0};
                    // A carry out of the tens nibble means more than two digits.
                    r_ovf  <= r_ovf | w_bcd_adj[7];
                    r_step <= r_step + 3'd1;
                end
                c_st_enc: begin
                    r_signal <= w_signal_nxt;
                end
                default: ;
            endcase
        end
    end

    assign Busy   = (r_state == c_st_shift) || (r_state == c_st_enc);
    assign Done   = r_done;
    assign Signal = r_signal;

endmodule
`default_nettype wire
